// File: rtl/tdm_mux6.sv
// tdm_mux6 -- six-lane to one-lane gathering multiplexer with a single
// registered output stage (lane accept to out_valid latency of one cycle).
//
// Scheduling policy is chosen at build time:
//   TDM6_SKIP_IDLE_EN undefined : fixed-slot TDM; the slot pointer visits
//                                 lanes 0..5 in turn on every load cycle and
//                                 an idle slot yields a bubble.
//   TDM6_SKIP_IDLE_EN defined   : work-conserving round robin starting after
//                                 the last granted lane.
// Ports, reset values and latency are identical in both builds.

module tdm_mux6 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6*WIDTH-1:0]   in_data,
   input  logic [5:0]           in_valid,
   output logic [5:0]           in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [2:0]           out_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sof
);

   localparam int unsigned NUM_LANES = 6;
   localparam int unsigned SEL_W     = 3;
   localparam logic [SEL_W-1:0] LANE_FIRST = SEL_W'(0);
   localparam logic [SEL_W-1:0] LANE_LAST  = SEL_W'(NUM_LANES - 1);

   // Successor lane with wrap 5 -> 0; 6 and 7 are never produced.
   function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] idx);
      return (idx == LANE_LAST) ? LANE_FIRST : SEL_W'(idx + SEL_W'(1));
   endfunction

   // One-hot lane mask for a lane index.
   function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
      return NUM_LANES'(1) << idx;
   endfunction

   logic [WIDTH-1:0]     r_out_data;
   logic [SEL_W-1:0]     r_out_sel;
   logic                 r_out_valid;
   logic                 r_out_sof;

   logic                 w_load;
   logic                 w_grant_hit;
   logic [SEL_W-1:0]     w_grant_idx;
   logic [NUM_LANES-1:0] w_offer;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_sel_data;

   // The output register may take a new word when empty or being drained.
   assign w_load = ~r_out_valid | out_ready;

`ifdef TDM6_SKIP_IDLE_EN

   logic [SEL_W-1:0] r_last_grant;
   logic [SEL_W-1:0] w_cand;

   // Round-robin search: first valid lane after the last grant, with wrap.
   always_comb begin
      w_grant_hit = 1'b0;
      w_grant_idx = LANE_FIRST;
      w_cand      = r_last_grant;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         w_cand = next_lane(w_cand);
         if (!w_grant_hit && in_valid[w_cand]) begin
            w_grant_hit = 1'b1;
            w_grant_idx = w_cand;
         end
      end
      w_offer = w_grant_hit ? lane_onehot(w_grant_idx) : '0;
   end

   // Remember the granted lane; an idle load cycle leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= LANE_LAST;
      end else if (w_load && w_grant_hit) begin
         r_last_grant <= w_grant_idx;
      end
   end

`else

   logic [SEL_W-1:0] r_slot;

   // Fixed slot: the current slot lane is offered whether or not it is valid.
   always_comb begin
      w_grant_idx = r_slot;
      w_grant_hit = in_valid[r_slot];
      w_offer     = lane_onehot(r_slot);
   end

   // Slot pointer advances on every load cycle, used or idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= LANE_FIRST;
      end else if (w_load) begin
         r_slot <= next_lane(r_slot);
      end
   end

`endif

   // Handshake towards the lanes; nothing is offered while stalled or in reset.
   always_comb begin
      in_ready = '0;
      if (rst_n && w_load) begin
         in_ready = w_offer;
      end
   end

   assign w_accept = w_load & w_grant_hit;

   // Select the granted lane's word from the packed input bus.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < int'(NUM_LANES); k++) begin
         if (w_grant_idx == SEL_W'(k)) begin
            w_sel_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output register: capture on accept, go empty on an idle load, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_sel   <= LANE_FIRST;
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
      end else if (w_load) begin
         if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_out_sof   <= (w_grant_idx == LANE_FIRST);
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;
   assign out_sof   = r_out_sof;

endmodule

// File: tb/tb_tdm_mux6.sv
// tb_tdm_mux6 -- directed and scoreboard bench for tdm_mux6 (WIDTH = 8).
// Build-specific expectations follow TDM6_SKIP_IDLE_EN.

module tb_tdm_mux6;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 10240;

   logic                clk;
   logic                rst_n;
   logic [6*WIDTH-1:0]  in_data;
   logic [5:0]          in_valid;
   logic [5:0]          in_ready;
   logic [WIDTH-1:0]    out_data;
   logic [2:0]          out_sel;
   logic                out_valid;
   logic                out_ready;
   logic                out_sof;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] fifo [6][DEPTH];
   int               head [6];
   int               tail [6];

   tdm_mux6 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sof   (out_sof)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic set_ramp_data();
      for (int k = 0; k < 6; k++) in_data[k*WIDTH +: WIDTH] = 8'(16 + k);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 6'h3F;
      out_ready = 1'b1;
      set_ramp_data();
      #22;
      n_checks++;
      if ({out_valid, out_sof, out_sel, out_data} !== 13'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got v=%b sof=%b sel=%0d data=%h expected all zero",
                  out_valid, out_sof, out_sel, out_data);
      end
      n_checks++;
      if (in_ready !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b expected 000000", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 6'b000001) begin
         n_errors++;
         $display("FAIL post_reset_ready: got %b expected 000001", in_ready);
      end
   endtask

   task automatic test_all_valid();
      logic [2:0] es;
      in_valid  = 6'h3F;
      out_ready = 1'b1;
      set_ramp_data();
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         es = 3'(i % 6);
         n_checks++;
         if ({out_valid, out_sof, out_sel, out_data} !==
             {1'b1, (es == 3'd0), es, 8'(16 + (i % 6))}) begin
            n_errors++;
            $display("FAIL all_valid[%0d]: got v=%b sof=%b sel=%0d data=%h expected v=1 sof=%b sel=%0d data=%h",
                     i, out_valid, out_sof, out_sel, out_data, (es == 3'd0), es, 8'(16 + (i % 6)));
         end
         n_checks++;
         if (in_ready !== 6'(6'd1 << ((i + 1) % 6))) begin
            n_errors++;
            $display("FAIL all_valid_ready[%0d]: got %b expected %b",
                     i, in_ready, 6'(6'd1 << ((i + 1) % 6)));
         end
      end
   endtask

`ifndef TDM6_SKIP_IDLE_EN
   task automatic test_single_lane();
      logic        ev;
      logic [7:0]  ed;
      logic [2:0]  es;
      in_valid  = 6'b001000;
      out_ready = 1'b1;
      set_ramp_data();
      in_data[3*WIDTH +: WIDTH] = 8'hA3;
      apply_reset();
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         ev = ((n - 1) % 6 == 3);
         ed = (n >= 4) ? 8'hA3 : 8'h00;
         es = (n >= 4) ? 3'd3 : 3'd0;
         n_checks++;
         if ({out_valid, out_sof, out_sel, out_data} !== {ev, 1'b0, es, ed}) begin
            n_errors++;
            $display("FAIL single_lane[%0d]: got v=%b sof=%b sel=%0d data=%h expected v=%b sof=0 sel=%0d data=%h",
                     n, out_valid, out_sof, out_sel, out_data, ev, es, ed);
         end
         n_checks++;
         if (in_ready !== 6'(6'd1 << (n % 6))) begin
            n_errors++;
            $display("FAIL single_lane_ready[%0d]: got %b expected %b",
                     n, in_ready, 6'(6'd1 << (n % 6)));
         end
      end
   endtask
`else
   task automatic test_skip_idle();
      logic [2:0] es;
      in_valid  = 6'b010010;
      out_ready = 1'b1;
      set_ramp_data();
      in_data[1*WIDTH +: WIDTH] = 8'h21;
      in_data[4*WIDTH +: WIDTH] = 8'h24;
      apply_reset();
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         es = (n % 2 == 1) ? 3'd1 : 3'd4;
         n_checks++;
         if ({out_valid, out_sof, out_sel, out_data} !== {1'b1, 1'b0, es, 8'h20 + 8'(es)}) begin
            n_errors++;
            $display("FAIL skip_idle[%0d]: got v=%b sof=%b sel=%0d data=%h expected v=1 sof=0 sel=%0d data=%h",
                     n, out_valid, out_sof, out_sel, out_data, es, 8'h20 + 8'(es));
         end
         n_checks++;
         if (in_ready !== ((n % 2 == 1) ? 6'b010000 : 6'b000010)) begin
            n_errors++;
            $display("FAIL skip_idle_ready[%0d]: got %b", n, in_ready);
         end
      end
   endtask
`endif

   task automatic test_stall();
      in_valid  = 6'h3F;
      out_ready = 1'b1;
      set_ramp_data();
      apply_reset();
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'd0, 8'h10}) begin
         n_errors++;
         $display("FAIL stall_first: got v=%b sel=%0d data=%h expected v=1 sel=0 data=10",
                  out_valid, out_sel, out_data);
      end
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         n_checks++;
         if (in_ready !== 6'b0) begin
            n_errors++;
            $display("FAIL stall_ready[%0d]: got %b expected 000000", j, in_ready);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, out_sof, out_sel, out_data} !== {1'b1, 1'b1, 3'd0, 8'h10}) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got v=%b sof=%b sel=%0d data=%h expected v=1 sof=1 sel=0 data=10",
                     j, out_valid, out_sof, out_sel, out_data);
         end
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({out_valid, out_sel, out_data} !== {1'b1, 3'(i % 6), 8'(16 + (i % 6))}) begin
            n_errors++;
            $display("FAIL stall_resume[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                     i, out_valid, out_sel, out_data, i % 6, 8'(16 + (i % 6)));
         end
      end
   endtask

   task automatic test_async_reset();
      in_valid  = 6'h3F;
      out_ready = 1'b1;
      set_ramp_data();
      apply_reset();
      repeat (3) @(posedge clk);
      #4;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_sof, out_sel, out_data} !== 13'd0) begin
         n_errors++;
         $display("FAIL async_reset_clear: got v=%b sof=%b sel=%0d data=%h expected all zero",
                  out_valid, out_sof, out_sel, out_data);
      end
      n_checks++;
      if (in_ready !== 6'b0) begin
         n_errors++;
         $display("FAIL async_reset_ready: got %b expected 000000", in_ready);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_sof, out_sel, out_data} !== {1'b1, 1'b1, 3'd0, 8'h10}) begin
         n_errors++;
         $display("FAIL async_reset_restart: got v=%b sof=%b sel=%0d data=%h expected v=1 sof=1 sel=0 data=10",
                  out_valid, out_sof, out_sel, out_data);
      end
   endtask

   task automatic test_random();
      int l;
      for (int k = 0; k < 6; k++) begin
         head[k] = 0;
         tail[k] = 0;
      end
      in_valid  = 6'b0;
      out_ready = 1'b0;
      apply_reset();
      for (int i = 0; i < 10004; i++) begin
         @(posedge clk);
         #1;
         if (i < 10000) begin
            in_valid  = 6'($urandom);
            in_data   = 48'({$urandom(), $urandom()});
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 6'b0;
            out_ready = 1'b1;
         end
         #2;
         n_checks++;
         if ((in_ready & (in_ready - 6'd1)) !== 6'b0) begin
            n_errors++;
            $display("FAIL rand_onehot[%0d]: in_ready=%b", i, in_ready);
         end
         if (out_valid && !out_ready) begin
            n_checks++;
            if (in_ready !== 6'b0) begin
               n_errors++;
               $display("FAIL rand_stall_ready[%0d]: got %b expected 000000", i, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            l = int'(out_sel);
            if (l > 5) begin
               n_errors++;
               $display("FAIL rand_sel_range[%0d]: got sel=%0d expected 0..5", i, out_sel);
            end else if (head[l] == tail[l]) begin
               n_errors++;
               $display("FAIL rand_unexpected[%0d]: got sel=%0d data=%h expected no word", i, out_sel, out_data);
            end else begin
               if ({out_data, out_sof} !== {fifo[l][head[l]], (l == 0)}) begin
                  n_errors++;
                  $display("FAIL rand_order[%0d]: lane %0d got data=%h sof=%b expected data=%h sof=%b",
                           i, l, out_data, out_sof, fifo[l][head[l]], (l == 0));
               end
               head[l]++;
            end
         end
         for (int k = 0; k < 6; k++) begin
            if (in_valid[k] && in_ready[k] && tail[k] < int'(DEPTH)) begin
               fifo[k][tail[k]] = in_data[k*WIDTH +: WIDTH];
               tail[k]++;
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (head[k] != tail[k]) begin
            n_errors++;
            $display("FAIL rand_drain lane %0d: got %0d words out expected %0d", k, head[k], tail[k]);
         end
      end
   endtask

   initial begin
      in_data   = '0;
      in_valid  = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_all_valid();
`ifndef TDM6_SKIP_IDLE_EN
      test_single_lane();
`else
      test_skip_idle();
`endif
      test_stall();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tdm_mux6.md
TDM_MUX6 -- requirements
Module: tdm_mux6

Interface
REQ-001 Parameter WIDTH, default 8, lane data width in bits (1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  6*WIDTH  six lanes packed, lane k at bits [k*WIDTH +: WIDTH].
REQ-005 in_valid  input  6  lane k offers a word.
REQ-006 in_ready  output  6  lane k word is accepted this cycle (accept = in_valid[k] & in_ready[k]).
REQ-007 out_data  output  WIDTH  registered selected word.
REQ-008 out_sel  output  3  registered source lane index 0..5, drives the downstream 1:6 demux select.
REQ-009 out_valid  output  1  out_data/out_sel hold a word.
REQ-010 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-011 out_sof  output  1  registered; high with the word whose out_sel is 0, marks frame start.

Function
REQ-012 Block is the 6:1 gathering end of the 1:6 demux path: one output register stage, latency exactly 1 cycle from lane accept to out_valid.
REQ-013 load = !out_valid | out_ready; output register updates only when load is 1.
REQ-014 When load is 0 (stall): out_data, out_sel, out_sof, out_valid held; in_ready = 0 on all lanes; slot/grant state frozen.
REQ-015 At most one bit of in_ready is high in any cycle; in_ready is combinational from state, in_valid and out_ready.
REQ-016 On accept from lane k: out_data <= lane k data, out_sel <= k, out_valid <= 1, out_sof <= (k == 0).
REQ-017 On load with no accept: out_valid <= 0; out_data, out_sel and out_sof hold their previous values.
REQ-018 Lane indices wrap 5 -> 0; lanes and selects 6 and 7 are never produced.
REQ-019 Data is never dropped or duplicated; a lane word held while its in_ready is 0 waits indefinitely.
REQ-020 Simultaneous output transfer and new accept in the same cycle is permitted (full throughput, one word per cycle).

Reset
REQ-021 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, out_sof = 0, in_ready = 0, slot pointer = 0, last_grant = 5.
REQ-022 Reset asserted mid-transfer discards the output register contents immediately, without waiting for a clock edge.
REQ-023 The first cycle after reset release is a normal load cycle that starts at lane 0.

Configuration
REQ-024 Macro TDM6_SKIP_IDLE_EN selects the lane scheduling policy.
REQ-025 Without the macro (fixed-slot TDM): slot pointer p; on load, in_ready[p] = 1; p advances p+1 mod 6 on every load cycle whether lane p is valid or not; an idle slot produces out_valid = 0 for that slot.
REQ-026 With the macro (work-conserving round robin): on load, grant the first lane with in_valid = 1 searching from (last_grant+1) mod 6 upward with wrap; in_ready of that lane = 1; last_grant <= granted lane; no valid lane means out_valid <= 0 and last_grant unchanged.
REQ-027 Port list, reset values and latency are identical in both builds.

Verification
REQ-028 WIDTH=8, fixed build, all lanes valid with data 8'h10+k, out_ready=1 -> out_sel sequence 0,1,2,3,4,5,0..., out_data 10..15, out_sof high every 6th word, one word per cycle.
REQ-029 Fixed build, only lane 3 valid (8'hA3), out_ready=1 -> out_valid high 1 cycle in every 6, out_sel=3, out_data=A3, other cycles out_valid=0.
REQ-030 Skip-idle build, only lanes 1 and 4 valid -> alternating out_sel 1,4,1,4 at full rate, in_ready never high on lanes 0,2,3,5.
REQ-031 Either build, all valid, out_ready held 0 for 5 cycles after first word -> out_data/out_sel stable, in_ready=6'b0, resume continues at the next lane with no loss or duplicate.
REQ-032 Reset pulsed asynchronously (mid-cycle) while out_valid=1 -> out_valid, out_data, out_sel fall to 0 before the next edge; after release the first granted lane is 0.
REQ-033 Scoreboard: per-lane input order equals per-out_sel output order over 10000 random valid/ready cycles, both builds.
